am_pwm_demod: RTL and testbench

Receive-side counterpart of the team's AM PWM DAC. The block samples a 1-bit PWM bitstream with an amplitude-modulated sine duty cycle, measures each pulse width, tracks the peak duty over a fixed window of PWM frames, and converts that envelope peak back into a distance estimate. It sits at the loopback/test input and reconstructs the distance value that drove the modulator.

---
 rtl/am_pwm_demod.sv | 135 +++++++++++++
 tb/tb_am_pwm_demod.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/am_pwm_demod.sv
// AM PWM demodulator: measures pulse widths of a 1-bit PWM stream, tracks the peak
// duty over a window of samples and rescales that envelope peak into a distance value.
module am_pwm_demod #(
  parameter int WIDTH       = 13,
  parameter int COUNT_WIDTH = 7,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   pwm_in,
  output logic [COUNT_WIDTH:0]   duty,
  output logic                   duty_valid,
  output logic [WIDTH-1:0]       distance,
  output logic                   distance_valid
);

  localparam int                     FRAME_I  = 2 ** COUNT_WIDTH;
  localparam logic [COUNT_WIDTH:0]   FRAME    = (COUNT_WIDTH+1)'(FRAME_I);
  localparam logic [COUNT_WIDTH:0]   FRAME_M1 = (COUNT_WIDTH+1)'(FRAME_I - 1);
  localparam logic [COUNT_WIDTH:0]   CNT_ONE  = (COUNT_WIDTH+1)'(1);
  localparam logic [WINDOW_LOG2-1:0] SCNT_LAST = '1;
  localparam logic [WINDOW_LOG2-1:0] SCNT_ONE  = WINDOW_LOG2'(1);
  localparam logic [31:0]            MAXD      = 32'(2 ** WIDTH - 1);

  typedef enum logic {ST_LOW, ST_HIGH} state_t;

  state_t                 r_state;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [COUNT_WIDTH:0]   r_cnt;
  logic [COUNT_WIDTH:0]   r_peak;
  logic [WINDOW_LOG2-1:0] r_scnt;
  logic                   r_done;

  logic                   w_s;
  logic [COUNT_WIDTH:0]   w_max;
  logic [31:0]            w_scaled;
  logic [WIDTH-1:0]       w_dist;

  assign w_s   = r_sync2;
  assign w_max = (duty > r_peak) ? duty : r_peak;

  // p*8 + p/32 approximates p*2048/255 without a multiplier
  assign w_scaled = (32'(r_peak) << 3) + (32'(r_peak) >> 5);
  assign w_dist   = (w_scaled > MAXD) ? MAXD[WIDTH-1:0] : w_scaled[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

  // Pulse-width FSM; a full frame without an edge still yields a 0 or FRAME sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_LOW;
      r_cnt      <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
    end else if (!enable) begin
      r_state    <= ST_LOW;
      r_cnt      <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      case (r_state)
        ST_LOW: begin
          if (w_s) begin
            r_state <= ST_HIGH;
            r_cnt   <= CNT_ONE;
          end else if (r_cnt == FRAME_M1) begin
            duty       <= '0;
            duty_valid <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!w_s) begin
            duty       <= r_cnt;
            duty_valid <= 1'b1;
            r_state    <= ST_LOW;
            r_cnt      <= '0;
          end else if (r_cnt == FRAME) begin
            duty       <= FRAME;
            duty_valid <= 1'b1;
            r_cnt      <= CNT_ONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= ST_LOW;
      endcase
    end
  end

  // A sample landing in the clear cycle opens the next window instead of being lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak         <= '0;
      r_scnt         <= '0;
      r_done         <= 1'b0;
      distance       <= '0;
      distance_valid <= 1'b0;
    end else if (!enable) begin
      r_peak         <= '0;
      r_scnt         <= '0;
      r_done         <= 1'b0;
      distance_valid <= 1'b0;
    end else begin
      distance_valid <= r_done;
      r_done         <= duty_valid && (r_scnt == SCNT_LAST);
      if (r_done) begin
        distance <= w_dist;
        if (duty_valid) begin
          r_peak <= duty;
          r_scnt <= SCNT_ONE;
        end else begin
          r_peak <= '0;
          r_scnt <= '0;
        end
      end else if (duty_valid) begin
        r_peak <= w_max;
        r_scnt <= r_scnt + SCNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_am_pwm_demod.sv
// Bench for am_pwm_demod: PWM runs are described as (level, length); expected duty and
// distance strobes are derived from run lengths and grouped into 256-sample windows.
module tb_am_pwm_demod;

  localparam int WIDTH = 13;
  localparam int CW    = 7;
  localparam int WL    = 8;
  localparam int FRAME = 128;
  localparam int WIN   = 256;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CW:0]      duty;
  logic             duty_valid;
  logic [WIDTH-1:0] distance;
  logic             distance_valid;

  am_pwm_demod #(.WIDTH(WIDTH), .COUNT_WIDTH(CW), .WINDOW_LOG2(WL)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
    .duty(duty), .duty_valid(duty_valid),
    .distance(distance), .distance_valid(distance_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  int obs_dt[$], obs_dv[$], obs_xt[$], obs_xv[$];
  int exp_dt[$], exp_dv[$], exp_xt[$], exp_xv[$];

  always @(negedge clk) begin
    if (duty_valid === 1'b1) begin
      obs_dt.push_back(cyc);
      obs_dv.push_back(int'(duty));
    end
    if (distance_valid === 1'b1) begin
      obs_xt.push_back(cyc);
      obs_xv.push_back(int'(distance));
    end
  end

  int anchor = 0;
  int win_n = 0;
  int win_max = 0;
  int last_dist = 0;
  int last_duty = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int scale(input int p);
    int s;
    s = p * 8 + p / 32;
    return (s > 8191) ? 8191 : s;
  endfunction

  task automatic push_duty(input int t, input int v);
    exp_dt.push_back(t);
    exp_dv.push_back(v);
    last_duty = v;
    win_n++;
    if (v > win_max) win_max = v;
    if (win_n == WIN) begin
      exp_xt.push_back(t + 2);
      exp_xv.push_back(scale(win_max));
      last_dist = scale(win_max);
      win_n = 0;
      win_max = 0;
    end
  endtask

  // High run of len clocks: a FRAME sample every FRAME clocks, then the remainder at the fall
  task automatic run_high(input int len);
    int c;
    int m;
    c = cyc;
    m = (len - 1) / FRAME;
    pwm_in = 1'b1;
    for (int j = 1; j <= m; j++) push_duty(c + 3 + FRAME * j, FRAME);
    push_duty(c + len + 3, len - FRAME * m);
    anchor = c + len + 3;
    repeat (len) @(negedge clk);
  endtask

  // Low run: a zero sample every FRAME clocks since the last sample while the line stays low
  task automatic run_low(input int len);
    int c;
    c = cyc;
    pwm_in = 1'b0;
    for (int t = anchor + FRAME; t < c + len + 3; t += FRAME) begin
      push_duty(t, 0);
      anchor = t;
    end
    repeat (len) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int gap);
    run_high(h);
    run_low(gap);
  endtask

  task automatic start_session();
    enable = 1'b1;
    anchor = cyc;
    win_n = 0;
    win_max = 0;
  endtask

  task automatic stop_session(input int hold, input bit toggle);
    enable = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (toggle) pwm_in = 1'($urandom_range(0, 1));
    end
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_distance", 32'(distance), 32'(last_dist));
    check("hold_duty", 32'(duty), 32'(last_duty));
  endtask

  function automatic int am_duty(input int k);
    real v;
    v = 63.0 + 61.0 * $sin(2.0 * 3.14159265358979 * k / 32.0);
    return int'($floor(v + 0.5));
  endfunction

  initial begin
    int n;
    // reset held with a toggling input
    enable = 1'b1;
    repeat (12) begin
      @(negedge clk);
      pwm_in = 1'($urandom_range(0, 1));
      check("rst_duty", 32'(duty), 32'd0);
      check("rst_duty_valid", 32'(duty_valid), 32'd0);
      check("rst_distance", 32'(distance), 32'd0);
      check("rst_distance_valid", 32'(distance_valid), 32'd0);
    end
    @(negedge clk);
    pwm_in = 1'b0;
    reset_n = 1'b1;
    anchor = cyc;
    repeat (2) begin
      @(negedge clk);
      check("rel_duty_valid", 32'(duty_valid), 32'd0);
      check("rel_distance_valid", 32'(distance_valid), 32'd0);
    end
    stop_session(2, 1'b0);

    // fixed duty 40: first frames at full length, later frame tails shortened
    start_session();
    for (int i = 0; i < WIN; i++) begin
      run_high(40);
      run_low((i < 16) ? 88 : 4);
    end
    run_low(10);
    stop_session(3, 1'b0);

    // loopback: AM sine envelope with peak duty 124, two windows
    start_session();
    for (int k = 0; k < 2 * WIN; k++) pulse(am_duty(k), 2);
    run_low(10);
    stop_session(3, 1'b0);

    // extremes: constant low, then constant high
    start_session();
    run_low(4 * FRAME + 50);
    stop_session(3, 1'b0);
    start_session();
    run_low(5);
    run_high(4 * FRAME);
    run_low(20);
    stop_session(3, 1'b0);

    // enable dropped mid-window with the input still toggling
    start_session();
    for (int i = 0; i < 99; i++) pulse($urandom_range(60, 99), $urandom_range(1, 4));
    pulse(120, 10);
    stop_session(500, 1'b1);

    // fresh window; its last sample (128) is followed one clock later by a sample of 1
    start_session();
    for (int i = 0; i < WIN - 1; i++) pulse($urandom_range(1, 20), $urandom_range(1, 3));
    pulse(FRAME + 1, 3);
    for (int i = 0; i < WIN - 1; i++) pulse($urandom_range(1, 20), $urandom_range(1, 3));
    run_low(10);
    stop_session(3, 1'b0);

    // asynchronous reset between clock edges mid-pulse
    start_session();
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_duty", 32'(duty), 32'd0);
    check("async_duty_valid", 32'(duty_valid), 32'd0);
    check("async_distance", 32'(distance), 32'd0);
    check("async_distance_valid", 32'(distance_valid), 32'd0);
    enable = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    check("duty_count", 32'(obs_dt.size()), 32'(exp_dt.size()));
    n = (obs_dt.size() < exp_dt.size()) ? obs_dt.size() : exp_dt.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("duty_cycle[%0d]", i), 32'(obs_dt[i]), 32'(exp_dt[i]));
      check($sformatf("duty_value[%0d]", i), 32'(obs_dv[i]), 32'(exp_dv[i]));
    end
    check("distance_count", 32'(obs_xt.size()), 32'(exp_xt.size()));
    n = (obs_xt.size() < exp_xt.size()) ? obs_xt.size() : exp_xt.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("distance_cycle[%0d]", i), 32'(obs_xt[i]), 32'(exp_xt[i]));
      check($sformatf("distance_value[%0d]", i), 32'(obs_xv[i]), 32'(exp_xv[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
